// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator. A clock divider paces the pixel counters,
// and sync/blank decodes, line/frame strobes and a frame counter are all registered together.

module vga_sync_gen_chk #(
  parameter int XBITS = 10,
  parameter int YBITS = 10,
  parameter int HTOT  = 800,
  parameter int VTOT  = 525
) (
  input logic             clk,
  input logic             reset,
  input logic             pix_tick,
  input logic [XBITS-1:0] x,
  input logic [YBITS-1:0] y,
  input logic             line_start,
  input logic             frame_start
);

  localparam logic [XBITS-1:0] X_LAST = XBITS'(HTOT - 1);
  localparam logic [YBITS-1:0] Y_LAST = YBITS'(VTOT - 1);

  a_x_range: assert property (@(posedge clk) disable iff (reset) x <= X_LAST);
  a_y_range: assert property (@(posedge clk) disable iff (reset) y <= Y_LAST);
  a_line_start: assert property (@(posedge clk) disable iff (reset)
    line_start |-> (pix_tick && (x == {XBITS{1'b0}})));
  a_frame_start: assert property (@(posedge clk) disable iff (reset)
    frame_start |-> (line_start && (y == {YBITS{1'b0}})));

endmodule

module vga_sync_gen #(
  parameter int   CLKDIV   = 4,
  parameter int   HVIS     = 640,
  parameter int   HFP      = 16,
  parameter int   HSW      = 96,
  parameter int   HBP      = 48,
  parameter int   VVIS     = 480,
  parameter int   VFP      = 10,
  parameter int   VSW      = 2,
  parameter int   VBP      = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   XBITS    = 10,
  parameter int   YBITS    = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_tick,
  output logic [XBITS-1:0] x,
  output logic [YBITS-1:0] y,
  output logic             activevideo,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int HTOT = HVIS + HFP + HSW + HBP;
  localparam int VTOT = VVIS + VFP + VSW + VBP;
  localparam int DW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int XW1  = XBITS + 1;
  localparam int YW1  = YBITS + 1;

  localparam logic [DW-1:0]    DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [XBITS-1:0] X_LAST   = XBITS'(HTOT - 1);
  localparam logic [YBITS-1:0] Y_LAST   = YBITS'(VTOT - 1);
  // Decode bounds carry one spare bit so an end bound equal to the total cannot alias.
  localparam logic [XBITS:0]   X_VIS    = XW1'(HVIS);
  localparam logic [XBITS:0]   X_HS_ON  = XW1'(HVIS + HFP);
  localparam logic [XBITS:0]   X_HS_OFF = XW1'(HVIS + HFP + HSW);
  localparam logic [YBITS:0]   Y_VIS    = YW1'(VVIS);
  localparam logic [YBITS:0]   Y_VS_ON  = YW1'(VVIS + VFP);
  localparam logic [YBITS:0]   Y_VS_OFF = YW1'(VVIS + VFP + VSW);

  logic [DW-1:0]    div_r;
  logic             pix_tick_r;
  logic [XBITS-1:0] x_r;
  logic [YBITS-1:0] y_r;
  logic             active_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             line_start_r;
  logic             frame_start_r;
  logic [7:0]       frame_count_r;

  logic             div_last_s;
  logic             wrap_x_s;
  logic             wrap_y_s;
  logic [XBITS-1:0] x_nxt_s;
  logic [YBITS-1:0] y_nxt_s;
  logic [XBITS:0]   x_ext_s;
  logic [YBITS:0]   y_ext_s;
  logic             active_nxt_s;
  logic             hsync_nxt_s;
  logic             vsync_nxt_s;

  // Next raster position and its decodes, committed only on a pixel advance.
  always_comb begin
    div_last_s = (div_r == DIV_LAST);
    wrap_x_s   = (x_r == X_LAST);
    wrap_y_s   = wrap_x_s && (y_r == Y_LAST);

    if (wrap_x_s) begin
      x_nxt_s = {XBITS{1'b0}};
    end else begin
      x_nxt_s = x_r + XBITS'(1);
    end

    if (wrap_y_s) begin
      y_nxt_s = {YBITS{1'b0}};
    end else if (wrap_x_s) begin
      y_nxt_s = y_r + YBITS'(1);
    end else begin
      y_nxt_s = y_r;
    end

    x_ext_s      = {1'b0, x_nxt_s};
    y_ext_s      = {1'b0, y_nxt_s};
    active_nxt_s = (x_ext_s < X_VIS) && (y_ext_s < Y_VIS);

    if ((x_ext_s >= X_HS_ON) && (x_ext_s < X_HS_OFF)) begin
      hsync_nxt_s = SYNC_POL;
    end else begin
      hsync_nxt_s = ~SYNC_POL;
    end

    if ((y_ext_s >= Y_VS_ON) && (y_ext_s < Y_VS_OFF)) begin
      vsync_nxt_s = SYNC_POL;
    end else begin
      vsync_nxt_s = ~SYNC_POL;
    end
  end

  // Divider, raster counters, registered decodes and strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r         <= {DW{1'b0}};
      pix_tick_r    <= 1'b0;
      x_r           <= {XBITS{1'b0}};
      y_r           <= {YBITS{1'b0}};
      active_r      <= 1'b1;
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      pix_tick_r    <= div_last_s;
      line_start_r  <= div_last_s && wrap_x_s;
      frame_start_r <= div_last_s && wrap_y_s;
      if (div_last_s) begin
        div_r    <= {DW{1'b0}};
        x_r      <= x_nxt_s;
        y_r      <= y_nxt_s;
        active_r <= active_nxt_s;
        hsync_r  <= hsync_nxt_s;
        vsync_r  <= vsync_nxt_s;
        if (wrap_y_s) begin
          frame_count_r <= frame_count_r + 8'd1;
        end
      end else begin
        div_r <= div_r + DW'(1);
      end
    end
  end

  assign pix_tick    = pix_tick_r;
  assign x           = x_r;
  assign y           = y_r;
  assign activevideo = active_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign frame_count = frame_count_r;

  vga_sync_gen_chk #(
    .XBITS(XBITS),
    .YBITS(YBITS),
    .HTOT (HTOT),
    .VTOT (VTOT)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick_r),
    .x          (x_r),
    .y          (y_r),
    .line_start (line_start_r),
    .frame_start(frame_start_r)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four builds (default, small CLKDIV=3 active-high, small CLKDIV=1,
// default CLKDIV=1) checked each cycle against an arithmetic model of elapsed clocks since reset.

module tb_vga_sync_gen;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       av;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } snap_t;

  typedef struct {
    int cd, hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
    bit pol;
  } cfg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       pt [4];
  logic [9:0] xo [4];
  logic [9:0] yo [4];
  logic       av [4];
  logic       hs [4];
  logic       vs [4];
  logic       ls [4];
  logic       fs [4];
  logic [7:0] fc [4];
  snap_t      obs [4];

  int     checks = 0;
  int     errors = 0;
  longint t = 0;

  for (genvar g = 0; g < 4; g++) begin : g_obs
    assign obs[g] = {pt[g], xo[g], yo[g], av[g], hs[g], vs[g], ls[g], fs[g], fc[g]};
  end

  vga_sync_gen #(.CLKDIV(4)) dut_a (
    .clk(clk), .reset(reset), .pix_tick(pt[0]), .x(xo[0]), .y(yo[0]), .activevideo(av[0]),
    .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0]));

  vga_sync_gen #(.CLKDIV(3), .HVIS(8), .HFP(2), .HSW(3), .HBP(3), .VVIS(4), .VFP(1), .VSW(2),
                 .VBP(1), .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .pix_tick(pt[1]), .x(xo[1]), .y(yo[1]), .activevideo(av[1]),
    .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1]));

  vga_sync_gen #(.CLKDIV(1), .HVIS(8), .HFP(2), .HSW(3), .HBP(3), .VVIS(4), .VFP(1), .VSW(2),
                 .VBP(1)) dut_c (
    .clk(clk), .reset(reset), .pix_tick(pt[2]), .x(xo[2]), .y(yo[2]), .activevideo(av[2]),
    .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2]));

  vga_sync_gen #(.CLKDIV(1)) dut_d (
    .clk(clk), .reset(reset), .pix_tick(pt[3]), .x(xo[3]), .y(yo[3]), .activevideo(av[3]),
    .hsync(hs[3]), .vsync(vs[3]), .line_start(ls[3]), .frame_start(fs[3]), .frame_count(fc[3]));

  function automatic cfg_t get_cfg(input int k);
    cfg_t c;
    case (k)
      0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      1:       c = '{3, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1};
      2:       c = '{1, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0};
      default: c = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    endcase
    return c;
  endfunction

  // Expected outputs after tc clocks since reset release: n pixels elapsed, position by div/mod.
  function automatic snap_t model(input int k, input longint tc);
    cfg_t   c = get_cfg(k);
    longint htot = longint'(c.hv + c.hfp + c.hsw + c.hbp);
    longint vtot = longint'(c.vv + c.vfp + c.vsw + c.vbp);
    longint n, xi, yi;
    snap_t  s;
    n    = tc / c.cd;
    xi   = n % htot;
    yi   = (n / htot) % vtot;
    s.pt = (tc > 0) && ((tc % c.cd) == 0);
    s.x  = 10'(xi);
    s.y  = 10'(yi);
    s.av = (xi < c.hv) && (yi < c.vv);
    s.hs = (xi >= c.hv + c.hfp && xi < c.hv + c.hfp + c.hsw) ? c.pol : !c.pol;
    s.vs = (yi >= c.vv + c.vfp && yi < c.vv + c.vfp + c.vsw) ? c.pol : !c.pol;
    s.ls = s.pt && (xi == 0);
    s.fs = s.ls && (yi == 0);
    s.fc = 8'((n / (htot * vtot)) % 256);
    return s;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    snap_t e;
    int first_tick = -1;
    do_reset(3);
    for (int k = 0; k < 4; k++) begin
      e = model(k, 0);
      checks++;
      if (obs[k] !== e) begin
        errors++;
        $display("FAIL reset_state dut=%0d got %p exp %p", k, obs[k], e);
      end
    end
    checks++;
    if (hs[0] !== 1'b1 || vs[0] !== 1'b1 || av[0] !== 1'b1 || xo[0] !== 10'd0 ||
        yo[0] !== 10'd0 || fc[0] !== 8'd0 || pt[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got hs=%b vs=%b av=%b x=%0d y=%0d fc=%0d pt=%b exp 1 1 1 0 0 0 0",
               hs[0], vs[0], av[0], xo[0], yo[0], fc[0], pt[0]);
    end
    for (int c = 0; c < 20 && first_tick < 0; c++) begin
      step();
      if (pt[0] === 1'b1) first_tick = int'(t);
    end
    checks++;
    if (first_tick != 4) begin
      errors++;
      $display("FAIL first_tick got %0d exp 4", first_tick);
    end
  endtask

  task automatic test_line();
    snap_t e;
    int lim = 0, ticks = 0, ls_cnt = 0, hs_ticks = 0, hs_first = -1, hs_last = -1;
    do_reset(2);
    while (ticks < 800 && t < 4000) begin
      step();
      e = model(0, t);
      if (lim < 5) begin
        checks++;
        if (obs[0] !== e) begin
          errors++; lim++;
          $display("FAIL line_walk t=%0d got %p exp %p", t, obs[0], e);
        end
      end
      if (pt[0] === 1'b1) begin
        ticks++;
        if (ls[0] === 1'b1) ls_cnt++;
        if (hs[0] === 1'b0) begin
          hs_ticks++;
          if (hs_first < 0) hs_first = int'(xo[0]);
          hs_last = int'(xo[0]);
        end
      end
    end
    checks++;
    if (ticks != 800 || ls_cnt != 1 || xo[0] !== 10'd0 || yo[0] !== 10'd1 || ls[0] !== 1'b1) begin
      errors++;
      $display("FAIL line_end got ticks=%0d ls=%0d x=%0d y=%0d ls_now=%b exp 800 1 0 1 1",
               ticks, ls_cnt, xo[0], yo[0], ls[0]);
    end
    checks++;
    if (hs_ticks != 96 || hs_first != 656 || hs_last != 751) begin
      errors++;
      $display("FAIL hsync_span got n=%0d %0d..%0d exp 96 656..751", hs_ticks, hs_first, hs_last);
    end
  endtask

  task automatic test_frame();
    snap_t e;
    int lim = 0, av_ticks = 0, vs_ticks = 0, fs_t = -1;
    do_reset(1);
    while (fs_t < 0 && t < 1000) begin
      step();
      e = model(1, t);
      if (lim < 5) begin
        checks++;
        if (obs[1] !== e) begin
          errors++; lim++;
          $display("FAIL frame_walk t=%0d got %p exp %p", t, obs[1], e);
        end
      end
      if (pt[1] === 1'b1) begin
        if (av[1] === 1'b1) av_ticks++;
        if (vs[1] === 1'b1) vs_ticks++;
      end
      if (fs[1] === 1'b1) fs_t = int'(t);
    end
    checks++;
    if (fs_t != 384 || fc[1] !== 8'd1) begin
      errors++;
      $display("FAIL frame_start got t=%0d fc=%0d exp t=384 fc=1", fs_t, fc[1]);
    end
    checks++;
    if (av_ticks != 32 || vs_ticks != 32) begin
      errors++;
      $display("FAIL frame_counts got av=%0d vs=%0d exp av=32 vs=32", av_ticks, vs_ticks);
    end
  endtask

  task automatic test_midframe_reset();
    snap_t e;
    longint tgt;
    int lim = 0;
    do_reset(1);
    while (t < 2808) step();
    checks++;
    if (hs[0] !== 1'b0 || xo[0] !== 10'd702) begin
      errors++;
      $display("FAIL pre_reset_hsync got hs=%b x=%0d exp 0 702", hs[0], xo[0]);
    end
    do_reset(1);
    checks++;
    if (hs[0] !== 1'b1 || xo[0] !== 10'd0 || yo[0] !== 10'd0 || pt[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_a got hs=%b x=%0d y=%0d pt=%b exp 1 0 0 0", hs[0], xo[0], yo[0], pt[0]);
    end
    tgt = longint'((32 + 10 + $urandom_range(0, 2)) * 3 + $urandom_range(0, 2));
    while (t < tgt) step();
    checks++;
    if (hs[1] !== 1'b1 || yo[1] !== 10'd2) begin
      errors++;
      $display("FAIL pre_reset_b got hs=%b y=%0d exp 1 2", hs[1], yo[1]);
    end
    do_reset(1);
    checks++;
    if (hs[1] !== 1'b0 || xo[1] !== 10'd0 || yo[1] !== 10'd0 || pt[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_b got hs=%b x=%0d y=%0d pt=%b exp 0 0 0 0", hs[1], xo[1], yo[1], pt[1]);
    end
    repeat (12) begin
      step();
      for (int k = 0; k < 2; k++) begin
        e = model(k, t);
        if (lim < 5) begin
          checks++;
          if (obs[k] !== e) begin
            errors++; lim++;
            $display("FAIL restart dut=%0d t=%0d got %p exp %p", k, t, obs[k], e);
          end
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    snap_t e;
    int lim = 0, fs_cnt = 0;
    logic [7:0] fc_before = 8'd0;
    do_reset(1);
    while (t < 32768) begin
      fc_before = fc[2];
      step();
      e = model(2, t);
      if (lim < 5) begin
        checks++;
        if (obs[2] !== e) begin
          errors++; lim++;
          $display("FAIL wrap_walk t=%0d got %p exp %p", t, obs[2], e);
        end
      end
      if (fs[2] === 1'b1) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 256 || fs[2] !== 1'b1 || fc[2] !== 8'd0 || fc_before !== 8'd255) begin
      errors++;
      $display("FAIL fc_wrap got frames=%0d fs=%b fc=%0d prev=%0d exp 256 1 0 255",
               fs_cnt, fs[2], fc[2], fc_before);
    end
  endtask

  task automatic test_clkdiv1();
    snap_t e;
    int lim = 0, pt_low = 0, ls_a = -1, ls_b = -1;
    do_reset(2);
    while (t < 1601) begin
      step();
      e = model(3, t);
      if (lim < 5) begin
        checks++;
        if (obs[3] !== e) begin
          errors++; lim++;
          $display("FAIL div1_walk t=%0d got %p exp %p", t, obs[3], e);
        end
      end
      if (pt[3] !== 1'b1) pt_low++;
      if (ls[3] === 1'b1) begin
        if (ls_a < 0) ls_a = int'(t);
        else if (ls_b < 0) ls_b = int'(t);
      end
    end
    checks++;
    if (pt_low != 0 || ls_a < 0 || (ls_b - ls_a) != 800) begin
      errors++;
      $display("FAIL div1_line got pt_low=%0d ls=%0d,%0d exp 0 and gap 800", pt_low, ls_a, ls_b);
    end
  endtask

  task automatic test_random_resets();
    snap_t e;
    int lim = 0, run, hold;
    for (int it = 0; it < 6; it++) begin
      run  = int'($urandom_range(1, 2000));
      hold = int'($urandom_range(1, 3));
      do_reset(hold);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k] !== model(k, 0)) begin
          errors++;
          $display("FAIL rand_reset dut=%0d got %p", k, obs[k]);
        end
      end
      repeat (run) begin
        step();
        for (int k = 0; k < 4; k++) begin
          e = model(k, t);
          if (lim < 8) begin
            checks++;
            if (obs[k] !== e) begin
              errors++; lim++;
              $display("FAIL rand_run dut=%0d t=%0d got %p exp %p", k, t, obs[k], e);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_midframe_reset();
    test_frame_wrap();
    test_clkdiv1();
    test_random_resets();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
